// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: integer WB (A) vs FP unit (B), A-priority with B promotion.
// Optional REGFILE_ARB_ZERO_GUARD_EN suppresses writes to r0 while still completing the handshake.
module regfile_wb_arbiter #(
    parameter int N            = 32,
    parameter int address_size = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [address_size-1:0] a_address,
    input  logic [N-1:0]            a_data,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [address_size-1:0] b_address,
    input  logic [N-1:0]            b_data,
    output logic                    write,
    output logic [address_size-1:0] rd_address,
    output logic [N-1:0]            write_data
);

    // A zero-wide counter is illegal, so STARVE_LIMIT=0 keeps one idle bit.
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        starve_cnt_q, starve_cnt_d;
    logic                    write_q, write_d;
    logic [address_size-1:0] rd_address_q, rd_address_d;
    logic [N-1:0]            write_data_q, write_data_d;

    logic                    grant_a;
    logic                    grant_b;
    logic                    handshake;
    logic [address_size-1:0] sel_address;
    logic [N-1:0]            sel_data;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        if (!reset) begin
            case (state_q)
                PRIO_A: begin
                    if (a_valid) begin
                        grant_a = 1'b1;
                    end else if (b_valid) begin
                        grant_b = 1'b1;
                    end
                    if (!b_valid || grant_b) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != LIMIT_C) begin
                        starve_cnt_d = starve_cnt_q + ONE_C;
                    end
                    if ((STARVE_LIMIT > 0) && b_valid && !grant_b && (starve_cnt_d == LIMIT_C)) begin
                        state_d = PRIO_B;
                    end
                end
                PRIO_B: begin
                    if (b_valid) begin
                        grant_b = 1'b1;
                    end else if (a_valid) begin
                        grant_a = 1'b1;
                    end
                    // Either B was granted or it withdrew: the promotion is spent.
                    state_d      = PRIO_A;
                    starve_cnt_d = '0;
                end
                default: begin
                    state_d      = PRIO_A;
                    starve_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        handshake    = grant_a | grant_b;
        sel_address  = grant_b ? b_address : a_address;
        sel_data     = grant_b ? b_data : a_data;
        write_d      = 1'b0;
        rd_address_d = rd_address_q;
        write_data_d = write_data_q;
        if (handshake) begin
`ifdef REGFILE_ARB_ZERO_GUARD_EN
            if (sel_address != '0) begin
                write_d      = 1'b1;
                rd_address_d = sel_address;
                write_data_d = sel_data;
            end
`else
            write_d      = 1'b1;
            rd_address_d = sel_address;
            write_data_d = sel_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PRIO_A;
            starve_cnt_q <= '0;
            write_q      <= 1'b0;
            rd_address_q <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            write_q      <= write_d;
            rd_address_q <= rd_address_d;
            write_data_q <= write_data_d;
        end
    end

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign write      = write_q;
    assign rd_address = rd_address_q;
    assign write_data = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios, then random traffic against a wait-count model.
module tb_regfile_wb_arbiter;

`ifdef REGFILE_ARB_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic [4:0]  a_address, b_address;
    logic [31:0] a_data, b_data;

    logic        a_ready, b_ready, write;
    logic [4:0]  rd_address;
    logic [31:0] write_data;

    logic        a_ready_z, b_ready_z, write_z;
    logic [4:0]  rd_address_z;
    logic [31:0] write_data_z;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.N(32), .address_size(5), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_address(a_address), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_address(b_address), .b_data(b_data),
        .write(write), .rd_address(rd_address), .write_data(write_data)
    );

    regfile_wb_arbiter #(.N(32), .address_size(5), .STARVE_LIMIT(0)) dut_z (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready_z), .a_address(a_address), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready_z), .b_address(b_address), .b_data(b_data),
        .write(write_z), .rd_address(rd_address_z), .write_data(write_data_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model state
    int          b_wait;
    bit          pa, pb, ga, gb, rst_r;
    logic [4:0]  pa_addr, pb_addr;
    logic [31:0] pa_data, pb_data;
    logic        exp_w;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    initial begin
        // 1: reset with both valid
        reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        a_address = 5'd1; a_data = 32'h1111; b_address = 5'd2; b_data = 32'h2222;
        @(negedge clk);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_z_a_ready", a_ready_z, 0);
        check("rst_write", write, 0);
        reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        check("rel_write", write, 0);
        check("rel_rd_address", rd_address, 0);
        check("rel_write_data", write_data, 0);

        // 2: single A write
        a_valid = 1'b1; a_address = 5'd3; a_data = 32'h40700000;
        #1;
        check("t2_a_ready", a_ready, 1);
        check("t2_b_ready", b_ready, 0);
        @(negedge clk);
        check("t2_write", write, 1);
        check("t2_rd_address", rd_address, 3);
        check("t2_write_data", write_data, 32'h40700000);
        a_valid = 1'b0;
        @(negedge clk);
        check("t2_write_drop", write, 0);
        check("t2_rd_hold", rd_address, 3);

        // 3/4: both held valid, AAAAB with limit 4, A always with limit 0
        b_valid = 1'b1; b_address = 5'd7; b_data = 32'hB0B0B0B0;
        for (int i = 0; i < 10; i++) begin
            a_valid = 1'b1; a_address = 5'(10 + i); a_data = 32'hA000_0000 + 32'(i);
            #1;
            check("t3_a_ready", a_ready, (i % 5 == 4) ? 0 : 1);
            check("t3_b_ready", b_ready, (i % 5 == 4) ? 1 : 0);
            check("t4_z_a_ready", a_ready_z, 1);
            check("t4_z_b_ready", b_ready_z, 0);
            @(negedge clk);
            check("t3_write", write, 1);
            check("t3_rd_address", rd_address, (i % 5 == 4) ? 7 : 10 + i);
            check("t4_z_rd_address", rd_address_z, 10 + i);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);

        // 5: B drops after 2 stalls, counting restarts
        a_valid = 1'b1; a_address = 5'd9; a_data = 32'h9;
        b_valid = 1'b1; b_address = 5'd5; b_data = 32'h5555;
        for (int i = 0; i < 2; i++) begin
            #1; check("t5_pre_a_ready", a_ready, 1);
            @(negedge clk);
        end
        b_valid = 1'b0;
        #1; check("t5_drop_a_ready", a_ready, 1);
        @(negedge clk);
        b_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t5_a_ready", a_ready, (i == 4) ? 0 : 1);
            check("t5_b_ready", b_ready, (i == 4) ? 1 : 0);
            @(negedge clk);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check("t5_rd_address", rd_address, 5);

        // 6: write to r0
        a_valid = 1'b1; a_address = 5'd0; a_data = 32'hFFFF;
        #1; check("t6_a_ready", a_ready, 1);
        @(negedge clk);
        a_valid = 1'b0;
        check("t6_write", write, GUARD ? 0 : 1);
        check("t6_rd_address", rd_address, GUARD ? 5 : 0);
        check("t6_write_data", write_data, GUARD ? 32'h5555 : 32'hFFFF);

        // random traffic against the model, starting from a reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        b_wait = 0; pa = 0; pb = 0;
        exp_w = 0; exp_addr = 0; exp_data = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            check("rnd_write", write, exp_w);
            check("rnd_rd_address", rd_address, exp_addr);
            check("rnd_write_data", write_data, exp_data);
            rst_r = ($urandom_range(0, 39) == 0);
            if (!pa && ($urandom_range(0, 2) != 0)) begin
                pa = 1; pa_addr = 5'($urandom_range(0, 31)); pa_data = $urandom;
            end
            if (!pb && ($urandom_range(0, 2) != 0)) begin
                pb = 1; pb_addr = 5'($urandom_range(0, 31)); pb_data = $urandom;
            end
            reset = rst_r;
            a_valid = pa; a_address = pa_addr; a_data = pa_data;
            b_valid = pb; b_address = pb_addr; b_data = pb_data;
            // B wins if alone, or once it has waited the full starvation limit
            gb = !rst_r && pb && (!pa || (LIM > 0 && b_wait >= LIM));
            ga = !rst_r && pa && !gb;
            #1;
            check("rnd_a_ready", a_ready, ga);
            check("rnd_b_ready", b_ready, gb);
            if (rst_r) begin
                exp_w = 0; exp_addr = 0; exp_data = 0; b_wait = 0;
            end else begin
                exp_w = 0;
                if (ga || gb) begin
                    if (!(GUARD && ((gb ? pb_addr : pa_addr) == 0))) begin
                        exp_w = 1;
                        exp_addr = gb ? pb_addr : pa_addr;
                        exp_data = gb ? pb_data : pa_data;
                    end
                end
                if (!pb || gb) b_wait = 0;
                else if (b_wait < LIM) b_wait++;
                if (ga) pa = 0;
                if (gb) pb = 0;
            end
            @(negedge clk);
        end
        check("rnd_write_final", write, exp_w);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
